// File: rtl/alarm_unit_if.sv
// Alarm unit bundle: live time digits, user controls, alarm outputs.
interface alarm_unit_if;
  logic       tick;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic [2:0] S1;
  logic [3:0] S2;
  logic       alarm_en;
  logic       set_alarm;
  logic       inc_h;
  logic       inc_m;
  logic       updown;
  logic       stop;
  logic       snooze;
  logic [1:0] AH1;
  logic [3:0] AH2;
  logic [2:0] AM1;
  logic [3:0] AM2;
  logic       ring;
  logic       snoozing;
  logic [1:0] snooze_used;

  modport master (
    output tick, H1, H2, M1, M2, S1, S2,
    output alarm_en, set_alarm,
    output inc_h, inc_m, updown,
    output stop, snooze,
    input  AH1, AH2, AM1, AM2,
    input  ring, snoozing, snooze_used
  );

  modport slave (
    input  tick, H1, H2, M1, M2, S1, S2,
    input  alarm_en, set_alarm,
    input  inc_h, inc_m, updown,
    input  stop, snooze,
    output AH1, AH2, AM1, AM2,
    output ring, snoozing, snooze_used
  );
endinterface

// File: rtl/alarm_unit.sv
// Alarm time store, match detector and ring/snooze state machine.
module alarm_unit #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input logic         clk,
  input logic         rst,
  alarm_unit_if.slave bus
);

  localparam int MAXT =
    (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int TW = $clog2(MAXT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] tnext;
  logic [1:0]    used_q, used_d;
  logic [4:0]    ahr_q, ahr_d;
  logic [5:0]    amin_q, amin_d;
  logic          match, match_q, trig;
  logic          force_idle, snz_ok;
  logic [6:0]    hnow, mnow;
  logic [1:0]    ah1;
  logic [2:0]    am1;

  always_comb begin
    ahr_d  = ahr_q;
    amin_d = amin_q;
    if (bus.set_alarm && bus.inc_h) begin
      if (bus.updown)
        ahr_d = (ahr_q == 5'd23) ? 5'd0
                                 : ahr_q + 5'd1;
      else
        ahr_d = (ahr_q == 5'd0) ? 5'd23
                                : ahr_q - 5'd1;
    end
    if (bus.set_alarm && bus.inc_m) begin
      if (bus.updown)
        amin_d = (amin_q == 6'd59) ? 6'd0
                                   : amin_q + 6'd1;
      else
        amin_d = (amin_q == 6'd0) ? 6'd59
                                  : amin_q - 6'd1;
    end
  end

  always_comb begin
    hnow  = {5'd0, bus.H1} * 7'd10
          + {3'd0, bus.H2};
    mnow  = {4'd0, bus.M1} * 7'd10
          + {3'd0, bus.M2};
    match = (hnow == {2'd0, ahr_q})
          & (mnow == {1'd0, amin_q})
          & (bus.S1 == 3'd0)
          & (bus.S2 == 4'd0);
    trig  = match & ~match_q
          & bus.alarm_en & ~bus.set_alarm;
  end

  always_comb begin
    ah1 = (ahr_q >= 5'd20) ? 2'd2 :
          (ahr_q >= 5'd10) ? 2'd1 : 2'd0;
    am1 = (amin_q >= 6'd50) ? 3'd5 :
          (amin_q >= 6'd40) ? 3'd4 :
          (amin_q >= 6'd30) ? 3'd3 :
          (amin_q >= 6'd20) ? 3'd2 :
          (amin_q >= 6'd10) ? 3'd1 : 3'd0;
  end

  assign bus.AH1 = ah1;
  assign bus.AH2 = 4'(ahr_q - {3'd0, ah1} * 5'd10);
  assign bus.AM1 = am1;
  assign bus.AM2 = 4'(amin_q - {3'd0, am1} * 6'd10);

  assign force_idle = ~bus.alarm_en | bus.set_alarm;
  assign snz_ok     = used_q < 2'(MAX_SNOOZE);
  assign tnext      = timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    used_d  = used_q;
    if (force_idle) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            state_d = RING;
            used_d  = 2'd0;
            timer_d = '0;
          end
        end
        RING: begin
          if (bus.stop) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (bus.snooze && snz_ok) begin
            state_d = SNOOZE;
            used_d  = used_q + 2'd1;
            timer_d = '0;
          end else if (bus.tick) begin
            // timer counts ticks already spent ringing
            if (tnext == TW'(RING_SEC)) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = tnext;
            end
          end
        end
        SNOOZE: begin
          if (bus.stop) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (bus.tick) begin
            if (tnext == TW'(SNOOZE_SEC)) begin
              state_d = RING;
              timer_d = '0;
            end else begin
              timer_d = tnext;
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      used_q  <= 2'd0;
      ahr_q   <= 5'd0;
      amin_q  <= 6'd0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      used_q  <= used_d;
      ahr_q   <= ahr_d;
      amin_q  <= amin_d;
      match_q <= match;
    end
  end

  assign bus.ring        = (state_q == RING);
  assign bus.snoozing    = (state_q == SNOOZE);
  assign bus.snooze_used = used_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: adjust, trigger, snooze, override, reset.
module tb_alarm_unit;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  alarm_unit_if b();

  alarm_unit #(
    .RING_SEC  (60),
    .SNOOZE_SEC(5),
    .MAX_SNOOZE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h,
                          input int m,
                          input int s);
    b.H1 = 2'(h / 10);
    b.H2 = 4'(h % 10);
    b.M1 = 3'(m / 10);
    b.M2 = 4'(m % 10);
    b.S1 = 3'(s / 10);
    b.S2 = 4'(s % 10);
  endtask

  task automatic p_inc(input bit h, input bit m);
    b.inc_h = h;
    b.inc_m = m;
    step();
    b.inc_h = 1'b0;
    b.inc_m = 1'b0;
  endtask

  task automatic p_ctl(input bit st, input bit sn);
    b.stop   = st;
    b.snooze = sn;
    step();
    b.stop   = 1'b0;
    b.snooze = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      b.tick = 1'b1;
      step();
      b.tick = 1'b0;
    end
  endtask

  // walk time across 07:30:00 so match rises once
  task automatic fire();
    set_time(7, 29, 59);
    step();
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
  endtask

  task automatic chk_alarm(input string tag,
                           input int hh,
                           input int mm);
    chk({tag, ".AH1"}, int'(b.AH1), hh / 10);
    chk({tag, ".AH2"}, int'(b.AH2), hh % 10);
    chk({tag, ".AM1"}, int'(b.AM1), mm / 10);
    chk({tag, ".AM2"}, int'(b.AM2), mm % 10);
  endtask

  initial begin
    nvec        = 0;
    nerr        = 0;
    rst         = 1'b0;
    b.tick      = 1'b0;
    b.alarm_en  = 1'b0;
    b.set_alarm = 1'b0;
    b.inc_h     = 1'b0;
    b.inc_m     = 1'b0;
    b.updown    = 1'b0;
    b.stop      = 1'b0;
    b.snooze    = 1'b0;
    set_time(12, 34, 56);
    step();
    step();
    chk_alarm("rst", 0, 0);
    chk("rst.ring", int'(b.ring), 0);
    chk("rst.snz", int'(b.snoozing), 0);
    chk("rst.used", int'(b.snooze_used), 0);
    rst = 1'b1;
    step();

    b.set_alarm = 1'b1;
    b.updown    = 1'b0;
    p_inc(1'b1, 1'b0);
    chk_alarm("dn_h", 23, 0);
    p_inc(1'b0, 1'b1);
    chk_alarm("dn_m", 23, 59);
    b.updown = 1'b1;
    p_inc(1'b0, 1'b1);
    chk_alarm("up_m_wrap", 23, 0);
    p_inc(1'b1, 1'b1);
    chk_alarm("both", 0, 1);
    for (int i = 0; i < 7; i++) p_inc(1'b1, 1'b0);
    for (int i = 0; i < 29; i++) p_inc(1'b0, 1'b1);
    chk_alarm("set0730", 7, 30);
    b.set_alarm = 1'b0;
    p_inc(1'b1, 1'b1);
    chk_alarm("ign_inc", 7, 30);

    b.alarm_en = 1'b1;
    set_time(7, 29, 59);
    step();
    chk("pre.ring", int'(b.ring), 0);
    set_time(7, 30, 0);
    chk("matchcyc.ring", int'(b.ring), 0);
    step();
    chk("trig.ring", int'(b.ring), 1);
    step();
    step();
    step();
    step();
    chk("hold.ring", int'(b.ring), 1);
    p_ctl(1'b1, 1'b0);
    chk("stop.ring", int'(b.ring), 0);
    step();
    step();
    chk("noretrig.ring", int'(b.ring), 0);

    fire();
    chk("t2.ring", int'(b.ring), 1);
    ticks(59);
    chk("t59.ring", int'(b.ring), 1);
    ticks(1);
    chk("t60.ring", int'(b.ring), 0);
    chk("t60.snz", int'(b.snoozing), 0);

    fire();
    chk("s.ring0", int'(b.ring), 1);
    chk("s.used0", int'(b.snooze_used), 0);
    p_ctl(1'b0, 1'b1);
    chk("s1.snz", int'(b.snoozing), 1);
    chk("s1.ring", int'(b.ring), 0);
    chk("s1.used", int'(b.snooze_used), 1);
    ticks(4);
    chk("s1t4.ring", int'(b.ring), 0);
    ticks(1);
    chk("s1t5.ring", int'(b.ring), 1);
    chk("s1t5.snz", int'(b.snoozing), 0);
    p_ctl(1'b0, 1'b1);
    chk("s2.used", int'(b.snooze_used), 2);
    p_ctl(1'b0, 1'b1);
    chk("s2ign.used", int'(b.snooze_used), 2);
    chk("s2ign.snz", int'(b.snoozing), 1);
    ticks(5);
    chk("s2t5.ring", int'(b.ring), 1);
    p_ctl(1'b0, 1'b1);
    chk("s3.used", int'(b.snooze_used), 3);
    ticks(5);
    chk("s3t5.ring", int'(b.ring), 1);
    p_ctl(1'b0, 1'b1);
    chk("s4.ring", int'(b.ring), 1);
    chk("s4.snz", int'(b.snoozing), 0);
    chk("s4.used", int'(b.snooze_used), 3);
    p_ctl(1'b1, 1'b0);
    chk("s4stop.ring", int'(b.ring), 0);

    fire();
    chk("ss.used0", int'(b.snooze_used), 0);
    p_ctl(1'b0, 1'b1);
    ticks(5);
    chk("ss.ring", int'(b.ring), 1);
    p_ctl(1'b1, 1'b1);
    chk("ss.ring1", int'(b.ring), 0);
    chk("ss.snz", int'(b.snoozing), 0);
    chk("ss.used", int'(b.snooze_used), 1);

    fire();
    p_ctl(1'b0, 1'b1);
    chk("dis.snz0", int'(b.snoozing), 1);
    b.alarm_en = 1'b0;
    step();
    chk("dis.snz", int'(b.snoozing), 0);
    chk("dis.ring", int'(b.ring), 0);
    ticks(5);
    chk("dis.ring5", int'(b.ring), 0);

    fire();
    step();
    chk("en0.ring", int'(b.ring), 0);
    b.alarm_en  = 1'b1;
    b.set_alarm = 1'b1;
    fire();
    step();
    chk("set1.ring", int'(b.ring), 0);
    b.set_alarm = 1'b0;
    step();
    chk_alarm("set1.keep", 7, 30);

    fire();
    chk("ar.ring0", int'(b.ring), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.ring", int'(b.ring), 0);
    chk_alarm("ar", 0, 0);
    step();
    rst = 1'b1;
    step();
    chk("ar.post", int'(b.ring), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage directly downstream of the timekeeping block. It holds a user-settable alarm time (hh:mm) and compares it against the live H1/H2/M1/M2/S1/S2 digit outputs of the timekeeper. It runs the ring/snooze state machine and exposes the alarm digits to the display multiplexer alongside the current time. One clock domain; all timing uses a 1 Hz enable tick, not a divided clock.

## Interface
- RING_SEC, 60: ring duration in ticks before auto-stop
- SNOOZE_SEC, 300: snooze duration in ticks
- MAX_SNOOZE, 3: snoozes honoured per alarm event; further snooze presses are ignored
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  1 Hz enable, one clk cycle wide
- H1 in 2, H2 in 4, M1 in 3, M2 in 4, S1 in 3, S2 in 4: current time digits (BCD per digit)
- alarm_en  in  1  alarm armed (level switch)
- set_alarm  in  1  alarm-adjust mode (level)
- inc_h  in  1  one-cycle pulse: step alarm hour
- inc_m  in  1  one-cycle pulse: step alarm minute
- updown  in  1  step direction for inc_h/inc_m: 1 = up, 0 = down
- stop  in  1  one-cycle pulse: silence alarm
- snooze  in  1  one-cycle pulse: snooze alarm
- AH1 out 2, AH2 out 4, AM1 out 3, AM2 out 4: alarm time digits
- ring  out  1  buzzer/LED drive
- snoozing  out  1  high while in SNOOZE
- snooze_used  out  2  snoozes consumed in current event

## Operation
- Alarm time stored binary: ahr 5 b (0–23), amin 6 b (0–59). Digits = value/10 and value%10, combinational.
- Adjust: while set_alarm=1, inc_h steps ahr and inc_m steps amin, in the direction given by updown.
  - Wrap: 23 up -> 0, 0 down -> 23; 59 up -> 0, 0 down -> 59.
  - No minute-to-hour carry.
  - inc_h and inc_m in the same cycle: both apply.
  - Pulses ignored while set_alarm=0.
- Match: match = (H1*10+H2 == ahr) & (M1*10+M2 == amin) & S1==0 & S2==0. match is registered as match_q.
- Trigger: match & ~match_q & alarm_en & ~set_alarm (rising edge). A single trigger per minute-zero second, however long match holds.
- FSM states IDLE, RING, SNOOZE.
  - IDLE: on trigger -> RING, snooze_used=0, ring timer=0.
  - RING: ring=1. Each tick increments the ring timer.
    - stop -> IDLE.
    - snooze with snooze_used<MAX_SNOOZE -> SNOOZE, snooze_used+1, snooze timer=0.
    - snooze with snooze_used==MAX_SNOOZE: ignored.
    - On the tick that brings the ring timer to RING_SEC -> IDLE.
  - SNOOZE: snoozing=1, ring=0. Each tick increments the snooze timer.
    - On the tick reaching SNOOZE_SEC -> RING, ring timer=0.
    - stop -> IDLE.
    - snooze ignored.
- Priority, highest first: alarm_en=0 or set_alarm=1 (force IDLE, clear timers) > stop > snooze > tick timeout > trigger. stop and snooze in the same cycle: stop wins.
- A trigger while in RING or SNOOZE is ignored.
- Timer widths: ceil(log2(max(RING_SEC,SNOOZE_SEC)+1)). One shared timer is permitted.

## Timing
- Reset (rst=0) asynchronous. Reset values:
  - ahr=0, amin=0, so AH1=AH2=AM1=AM2=0.
  - state IDLE; ring=0, snoozing=0, snooze_used=0; match_q=0; timers 0.
- Adjust latency: inc pulse at edge N -> new digits visible after edge N.
- Trigger latency: match rises in cycle N -> ring=1 from edge N+1.
- stop/snooze pulse at edge N -> ring=0 from edge N+1.
- Ring lasts exactly RING_SEC ticks: ring falls after the edge on which the RING_SEC-th tick is sampled.
- SNOOZE->RING transition occurs on the edge sampling the SNOOZE_SEC-th tick; ring=1 from that edge.
- tick coincident with stop: stop wins; the timer value is irrelevant.
- Reset mid-RING/SNOOZE: outputs return to reset values immediately, without waiting for a clock.

## Test plan
- Reset then adjust: rst pulse; set_alarm=1, updown=0, one inc_h -> AH1=2, AH2=3. One inc_m -> AM1=5, AM2=9. updown=1, one inc_m -> AM=00, AH unchanged (23).
- Trigger and timeout: alarm 07:30, time driven 07:29:59 -> 07:30:00 -> ring=1 one cycle later. Hold match for 5 cycles -> single trigger. 60 ticks (RING_SEC=60) -> ring=0, state IDLE.
- Snooze chain: MAX_SNOOZE=3, SNOOZE_SEC=5.
  - snooze in RING -> snoozing=1, ring=0, snooze_used=1.
  - After 5 ticks -> ring=1.
  - Repeat to snooze_used=3; fourth snooze ignored, ring stays 1.
- Simultaneous stop+snooze in RING -> IDLE, snooze_used unchanged, snoozing=0.
- Disarm/adjust override:
  - alarm_en=0 during SNOOZE -> IDLE next edge.
  - Match while set_alarm=1 -> no ring.
  - Match while alarm_en=0 -> no ring.
- Async reset mid-ring: rst low between edges while ring=1 -> ring=0 and alarm digits 00:00 before the next clk edge.
